bird_kinematics: RTL and testbench
==================================

# bird_kinematics

Parametrised fixed-point vertical physics engine for the player bird, replacing the fixed-step falling/rising state machine with velocity integration. It runs on a frame-rate `tick` strobe and applies gravity, flap impulse, terminal velocity and ceiling/floor clamping. It sits between the input debouncer (`flap`) and the renderer/collision checker (`bird_x`, `bird_y`), with game control supplying `enable`, `game_reset` and `collision`.

## Interface
- `COORD_W`, 11: integer pixel width of `bird_x`/`bird_y`.
- `FRAC_W`, 4: fractional bits of internal position and velocity.
- `VEL_W`, 8: signed velocity width, including `FRAC_W` fraction bits.
- `GRAVITY`, 4: velocity increment per tick, in 1/2^FRAC_W px/tick, positive.
- `FLAP_VEL`, -48: velocity loaded on flap, signed, negative means up.
- `MAX_FALL_VEL`, 96: terminal downward velocity, positive.
- `START_Y`, 200: spawn row in pixels.
- `BIRD_X`, 150: constant column in pixels.
- `Y_MIN`, 0: ceiling row in pixels.
- `Y_MAX`, 460: floor row in pixels.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `game_reset`  in  1  synchronous return to IDLE.
- `enable`  in  1  start of flight; level, sampled in IDLE.
- `tick`  in  1  one-cycle physics-step strobe.
- `flap`  in  1  flap request; level, rising edge detected internally.
- `collision`  in  1  pipe hit; freezes the bird.
- `bird_x`  out  COORD_W  constant `BIRD_X`.
- `bird_y`  out  COORD_W  integer part of position, registered.
- `velocity`  out  VEL_W  current signed velocity, registered.
- `state`  out  2  00 IDLE, 01 FLY, 10 DEAD.
- `floor_hit`  out  1  one-cycle pulse when the floor is reached.
- `ceil_hit`  out  1  one-cycle pulse on each ceiling clamp.

## Operation
- Internal position `pos` is unsigned, COORD_W+FRAC_W bits, in 1/2^FRAC_W px. `bird_y = pos >> FRAC_W`, truncated.
- Flap edge: `flap & ~flap_q`, where `flap_q` is registered. In FLY the edge sets `flap_pend`. A tick consumes `flap_pend`, or an edge arriving in the same cycle, and clears it. Edges seen in IDLE or DEAD are discarded and `flap_pend` is cleared.
- IDLE:
  - Hold `pos = START_Y<<FRAC_W` and `velocity = 0`.
  - `enable` → FLY on the next edge.
  - Ticks are ignored.
- FLY, on a tick with no collision:
  - Velocity update: `v' = flap_pend|edge ? FLAP_VEL : min(velocity+GRAVITY, MAX_FALL_VEL)`.
  - Position update: `p' = pos + sext(v')`, computed at COORD_W+FRAC_W+1 bits signed.
  - If `p' >= Y_MAX<<FRAC_W`: set `pos = Y_MAX<<FRAC_W` and `velocity = 0`, pulse `floor_hit`, go to DEAD.
  - Else if `p' <= Y_MIN<<FRAC_W`, which includes negative results: set `pos = Y_MIN<<FRAC_W` and `velocity = 0`, pulse `ceil_hit`, stay in FLY.
  - Otherwise: `pos = p'`, `velocity = v'`.
- FLY without a tick: hold `pos` and `velocity`.
- `collision` high in FLY → DEAD. No position update happens in that cycle, even if `tick` is high.
- DEAD: hold `pos` and `velocity`; leave only via `game_reset` or `reset`.
- Priority, highest first: `reset` > `game_reset` > `collision` > `tick`. A `game_reset` from any state returns to IDLE with spawn values on the next edge.

## Timing
- Reset values:
  - `state` = IDLE.
  - `bird_y` = START_Y.
  - `velocity` = 0.
  - `floor_hit` = `ceil_hit` = 0.
  - `flap_q` = `flap_pend` = 0.
  - `bird_x` = BIRD_X at all times.
- Latency:
  - A tick in cycle t is reflected in `bird_y`, `velocity` and the pulses at t+1.
  - A flap edge in cycle t affects the first tick at or after t.
  - `enable` in cycle t gives `state` = FLY at t+1; the first physics step happens on a tick at t+1 or later.
- Pulses are high for exactly one cycle.
- Back-to-back ticks on consecutive cycles are legal, and each performs one step.
- Multiple flap edges between ticks collapse into a single impulse.

## Test plan
- Reset/spawn: assert `reset` mid-flight, asynchronously between edges → `state` = 00, `bird_y` = 200, `velocity` = 0 immediately, with no clock edge needed.
- Gravity: apply `enable`, then 4 ticks with no flap → `velocity` = 4, 8, 12, 16 and `bird_y` = 200, 200, 201, 202.
- Terminal velocity: apply 30 ticks → `velocity` saturates at 96 from tick 24 onward; `bird_y` then advances 6 px per tick.
- Flap:
  - Flap edge 3 cycles before a tick → that tick sets `velocity` = -48 and `bird_y` falls by 3 px.
  - Two edges before one tick → one impulse only.
  - Edge in the same cycle as a tick → applied on that tick.
- Boundaries:
  - Fall until `p' >= 460<<4` → `bird_y` = 460, `velocity` = 0, one `floor_hit` pulse, `state` = 10.
  - Flap repeatedly near the top → `bird_y` = 0, `velocity` = 0, `ceil_hit` pulses, `state` stays 01.
- Collision/game_reset:
  - `collision` together with `tick` → DEAD with `bird_y` unchanged.
  - Later ticks and flaps → no change.
  - `game_reset` → IDLE with `bird_y` = 200 next cycle.
  - `game_reset` and `collision` in the same cycle → IDLE.

Source files
------------

// File: rtl/bird_kinematics.sv
// rtl/bird_kinematics.sv - fixed-point vertical physics for the player bird
module bird_kinematics #(
  parameter int COORD_W      = 11,
  parameter int FRAC_W       = 4,
  parameter int VEL_W        = 8,
  parameter int GRAVITY      = 4,
  parameter int FLAP_VEL     = -48,
  parameter int MAX_FALL_VEL = 96,
  parameter int START_Y      = 200,
  parameter int BIRD_X       = 150,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 460
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_reset,
  input  logic               enable,
  input  logic               tick,
  input  logic               flap,
  input  logic               collision,
  output logic [COORD_W-1:0] bird_x,
  output logic [COORD_W-1:0] bird_y,
  output logic [VEL_W-1:0]   velocity,
  output logic [1:0]         state,
  output logic               floor_hit,
  output logic               ceil_hit
);

  localparam int POS_W = COORD_W + FRAC_W;

  localparam logic [POS_W-1:0]        START_P = POS_W'(START_Y << FRAC_W);
  localparam logic signed [POS_W:0]   FLOOR_P = (POS_W+1)'(Y_MAX << FRAC_W);
  localparam logic signed [POS_W:0]   CEIL_P  = (POS_W+1)'(Y_MIN << FRAC_W);
  localparam logic signed [VEL_W-1:0] FLAP_V  = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_V  = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   MAX_V   = (VEL_W+1)'(MAX_FALL_VEL);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FLY  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t                  st;
  logic [POS_W-1:0]        pos;
  logic signed [VEL_W-1:0] vel;
  logic                    flap_q;
  logic                    flap_pend;
  logic                    flap_edge;
  logic signed [VEL_W:0]   v_sum;
  logic signed [VEL_W-1:0] v_next;
  logic signed [POS_W:0]   p_next;

  assign flap_edge = flap & ~flap_q;
  assign bird_x    = COORD_W'(BIRD_X);
  assign bird_y    = pos[POS_W-1:FRAC_W];
  assign velocity  = vel;
  assign state     = st;

  // Candidate velocity and position for a physics step taken this cycle.
  always_comb begin
    v_sum  = {vel[VEL_W-1], vel} + GRAV_V;
    v_next = vel;
    if (flap_pend || flap_edge) begin
      v_next = FLAP_V;
    end else if (v_sum > MAX_V) begin
      v_next = MAX_V[VEL_W-1:0];
    end else begin
      v_next = v_sum[VEL_W-1:0];
    end
    p_next = $signed({1'b0, pos}) + $signed({{(POS_W+1-VEL_W){v_next[VEL_W-1]}}, v_next});
  end

  // Game state, integration, boundary clamping and hit pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      pos       <= START_P;
      vel       <= '0;
      flap_q    <= 1'b0;
      flap_pend <= 1'b0;
      floor_hit <= 1'b0;
      ceil_hit  <= 1'b0;
    end else begin
      flap_q    <= flap;
      floor_hit <= 1'b0;
      ceil_hit  <= 1'b0;
      if (game_reset) begin
        st        <= IDLE;
        pos       <= START_P;
        vel       <= '0;
        flap_pend <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            pos       <= START_P;
            vel       <= '0;
            flap_pend <= 1'b0;
            if (enable) st <= FLY;
          end
          FLY: begin
            if (collision) begin
              st        <= DEAD;
              flap_pend <= 1'b0;
            end else if (tick) begin
              flap_pend <= 1'b0;
              if (p_next >= FLOOR_P) begin
                pos       <= FLOOR_P[POS_W-1:0];
                vel       <= '0;
                floor_hit <= 1'b1;
                st        <= DEAD;
              end else if (p_next <= CEIL_P) begin
                pos      <= CEIL_P[POS_W-1:0];
                vel      <= '0;
                ceil_hit <= 1'b1;
              end else begin
                pos <= p_next[POS_W-1:0];
                vel <= v_next;
              end
            end else if (flap_edge) begin
              flap_pend <= 1'b1;
            end
          end
          default: begin
            flap_pend <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_kinematics.sv
// tb/tb_bird_kinematics.sv - randomized and directed check of bird_kinematics
module tb_bird_kinematics;

  localparam int GRAVITY  = 4;
  localparam int FLAP_VEL = -48;
  localparam int MAX_FALL = 96;
  localparam int START_Y  = 200;
  localparam int Y_MIN    = 0;
  localparam int Y_MAX    = 460;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        game_reset = 1'b0;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic        flap = 1'b0;
  logic        collision = 1'b0;
  logic [10:0] bird_x;
  logic [10:0] bird_y;
  logic [7:0]  velocity;
  logic [1:0]  state;
  logic        floor_hit;
  logic        ceil_hit;

  int tests = 0;
  int fails = 0;

  // reference model: position in sixteenths of a pixel, plain integers
  int m_state, m_pos, m_vel, m_fh, m_ch;
  bit m_pend, m_flap_prev;

  bird_kinematics dut (
    .clk(clk), .reset(reset), .game_reset(game_reset), .enable(enable),
    .tick(tick), .flap(flap), .collision(collision), .bird_x(bird_x),
    .bird_y(bird_y), .velocity(velocity), .state(state),
    .floor_hit(floor_hit), .ceil_hit(ceil_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_pos = START_Y * 16; m_vel = 0;
    m_pend = 0; m_flap_prev = 0; m_fh = 0; m_ch = 0;
  endfunction

  function automatic void model_step();
    bit e;
    int v, p;
    e = flap && !m_flap_prev;
    m_flap_prev = flap;
    m_fh = 0; m_ch = 0;
    if (game_reset) begin
      m_state = 0; m_pos = START_Y * 16; m_vel = 0; m_pend = 0;
    end else if (m_state == 0) begin
      m_pos = START_Y * 16; m_vel = 0; m_pend = 0;
      if (enable) m_state = 1;
    end else if (m_state == 1) begin
      if (collision) begin
        m_state = 2; m_pend = 0;
      end else if (tick) begin
        if (m_pend || e) v = FLAP_VEL;
        else v = (m_vel + GRAVITY > MAX_FALL) ? MAX_FALL : m_vel + GRAVITY;
        p = m_pos + v;
        m_pend = 0;
        if (p >= Y_MAX * 16) begin
          m_pos = Y_MAX * 16; m_vel = 0; m_fh = 1; m_state = 2;
        end else if (p <= Y_MIN * 16) begin
          m_pos = Y_MIN * 16; m_vel = 0; m_ch = 1;
        end else begin
          m_pos = p; m_vel = v;
        end
      end else if (e) begin
        m_pend = 1;
      end
    end else begin
      m_pend = 0;
    end
  endfunction

  task automatic compare_all();
    chk("state", int'(state), m_state);
    chk("bird_y", int'(bird_y), m_pos / 16);
    chk("velocity", $signed(velocity), m_vel);
    chk("floor_hit", int'(floor_hit), m_fh);
    chk("ceil_hit", int'(ceil_hit), m_ch);
    chk("bird_x", int'(bird_x), 150);
  endtask

  task automatic step(input logic t, input logic f, input logic c,
                      input logic en, input logic gr);
    tick = t; flap = f; collision = c; enable = en; game_reset = gr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int y0, fh_cnt, ch_cnt, guard;
    bit seen_ceil;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // launch, then gravity-only ticks
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("fly_state", int'(state), 1);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 0, 0);
      chk("grav_vel", $signed(velocity), 4 * k);
      chk("grav_y", int'(bird_y), (k < 3) ? 200 : 198 + k);
      step(0, 0, 0, 0, 0);
    end
    // terminal velocity up to 30 ticks total
    for (int k = 5; k <= 30; k++) begin
      y0 = int'(bird_y);
      step(1, 0, 0, 0, 0);
      if (k >= 24) chk("term_vel", $signed(velocity), 96);
      if (k >= 25) chk("term_dy", int'(bird_y) - y0, 6);
    end

    // flap edge three cycles before a tick
    y0 = int'(bird_y);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("flap_vel", $signed(velocity), -48);
    chk("flap_dy", y0 - int'(bird_y), 3);
    // two edges collapse into one impulse
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("dbl_flap_vel", $signed(velocity), -48);
    step(1, 0, 0, 0, 0);
    chk("dbl_flap_next", $signed(velocity), -44);
    // edge in the same cycle as the tick
    step(1, 1, 0, 0, 0);
    chk("same_cyc_flap", $signed(velocity), -48);
    step(0, 0, 0, 0, 0);

    // fall to the floor
    fh_cnt = 0;
    guard = 0;
    while (state != 2'b10 && guard < 300) begin
      step(1, 0, 0, 0, 0);
      fh_cnt += int'(floor_hit);
      guard++;
    end
    chk("floor_state", int'(state), 2);
    chk("floor_y", int'(bird_y), 460);
    chk("floor_vel", $signed(velocity), 0);
    for (int k = 0; k < 3; k++) begin
      step(1, k[0], 0, 0, 0);
      fh_cnt += int'(floor_hit);
    end
    chk("floor_pulses", fh_cnt, 1);
    chk("dead_hold_y", int'(bird_y), 460);

    // respawn and flap into the ceiling
    step(0, 0, 0, 0, 1);
    chk("respawn_y", int'(bird_y), 200);
    chk("respawn_state", int'(state), 0);
    step(0, 0, 0, 1, 0);
    ch_cnt = 0;
    seen_ceil = 0;
    for (int k = 0; k < 120; k++) begin
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      if (ceil_hit) begin
        ch_cnt++;
        if (!seen_ceil) begin
          chk("ceil_y", int'(bird_y), 0);
          chk("ceil_vel", $signed(velocity), 0);
        end
        seen_ceil = 1;
      end
    end
    chk("ceil_seen", (ch_cnt > 1) ? 1 : 0, 1);
    chk("ceil_state", int'(state), 1);

    // collision coincident with a tick freezes the bird
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    y0 = int'(bird_y);
    step(1, 1, 1, 0, 0);
    chk("coll_state", int'(state), 2);
    chk("coll_y", int'(bird_y), y0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("coll_hold_y", int'(bird_y), y0);
    step(0, 0, 0, 0, 1);
    chk("gr_y", int'(bird_y), 200);
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 1);
    chk("gr_over_coll", int'(state), 0);

    // asynchronous reset in mid-flight, between edges
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_y", int'(bird_y), 200);
    chk("async_vel", $signed(velocity), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tick = 0; flap = 0; collision = 0; enable = 0; game_reset = 0;

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
